// File: rtl/axi_wb_mem_responder.sv
// AXI4 subordinate backed by an on-chip 64-bit word memory, serving a write-back
// dcache manager with a single outstanding write or read transaction.
package axi_wb_mem_responder_pkg;
   // Channel structs are sized for the responder's default widths.
   localparam int unsigned AddrW = 64;
   localparam int unsigned DataW = 64;
   localparam int unsigned IdW   = 4;
   localparam int unsigned StrbW = DataW / 8;

   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespSlvErr = 2'b10;
   localparam logic [1:0] RespDecErr = 2'b11;

   localparam logic [1:0] BurstFixed = 2'b00;
   localparam logic [1:0] BurstIncr  = 2'b01;
   localparam logic [1:0] BurstWrap  = 2'b10;

   typedef struct packed {
      logic [IdW-1:0]   aw_id;
      logic [AddrW-1:0] aw_addr;
      logic [7:0]       aw_len;
      logic [2:0]       aw_size;
      logic [1:0]       aw_burst;
      logic [5:0]       aw_atop;
      logic             aw_valid;
      logic [DataW-1:0] w_data;
      logic [StrbW-1:0] w_strb;
      logic             w_last;
      logic             w_valid;
      logic             b_ready;
      logic [IdW-1:0]   ar_id;
      logic [AddrW-1:0] ar_addr;
      logic [7:0]       ar_len;
      logic [2:0]       ar_size;
      logic [1:0]       ar_burst;
      logic             ar_valid;
      logic             r_ready;
   } axi_req_t;

   typedef struct packed {
      logic             aw_ready;
      logic             ar_ready;
      logic             w_ready;
      logic             b_valid;
      logic [IdW-1:0]   b_id;
      logic [1:0]       b_resp;
      logic             r_valid;
      logic [IdW-1:0]   r_id;
      logic [DataW-1:0] r_data;
      logic [1:0]       r_resp;
      logic             r_last;
   } axi_resp_t;
endpackage

module axi_wb_mem_responder
   import axi_wb_mem_responder_pkg::*;
#(
   parameter int unsigned AxiAddrWidth = 64,
   parameter int unsigned AxiDataWidth = 64,
   parameter int unsigned AxiIdWidth   = 4,
   parameter logic [63:0] MemBase      = 64'h8000_0000,
   parameter int unsigned MemWords     = 1024
) (
   input  logic      clk_i,
   input  logic      rst_i,
   input  axi_req_t  axi_req_i,
   output axi_resp_t axi_resp_o
);
   localparam int unsigned IdxW      = (MemWords > 1) ? $clog2(MemWords) : 1;
   localparam int unsigned StrbWidth = AxiDataWidth / 8;
   localparam logic [AxiAddrWidth-1:0] BaseAddr = AxiAddrWidth'(MemBase);

   typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_t;

   state_t                  r_state;
   state_t                  w_state_next;
   logic [AxiIdWidth-1:0]   r_id;
   logic [AxiAddrWidth-1:0] r_addr;
   logic [AxiAddrWidth-1:0] w_addr_next;
   logic [AxiAddrWidth-1:0] w_addr_adv;
   logic [7:0]              r_len;
   logic [7:0]              r_cnt;
   logic [1:0]              r_burst;
   logic                    r_slverr;
   logic                    r_decerr;
   logic                    r_rd_in_range;
   logic [AxiDataWidth-1:0] r_rdata;
   logic [AxiDataWidth-1:0] r_mem [MemWords];

   logic            w_aw_hs;
   logic            w_ar_hs;
   logic            w_w_hs;
   logic            w_r_hs;
   logic            w_last_beat;
   logic            w_cur_ok;
   logic            w_mem_we;
   logic [IdxW-1:0] w_wr_idx;
   logic [IdxW-1:0] w_rd_idx;
   axi_resp_t       w_resp;

   function automatic logic [AxiAddrWidth-1:0] word_index(input logic [AxiAddrWidth-1:0] a);
      return (a - BaseAddr) >> 3;
   endfunction

   function automatic logic in_range(input logic [AxiAddrWidth-1:0] a);
      return (a >= BaseAddr) && (word_index(a) < AxiAddrWidth'(MemWords));
   endfunction

   assign w_aw_hs     = (r_state == IDLE) && axi_req_i.aw_valid;
   assign w_ar_hs     = (r_state == IDLE) && !axi_req_i.aw_valid && axi_req_i.ar_valid;
   assign w_w_hs      = (r_state == WRITE) && axi_req_i.w_valid;
   assign w_r_hs      = (r_state == READ) && axi_req_i.r_ready;
   assign w_last_beat = (r_cnt == r_len);
   assign w_cur_ok    = in_range(r_addr);
   assign w_mem_we    = w_w_hs && w_cur_ok && !r_slverr;
   assign w_wr_idx    = IdxW'(word_index(r_addr));
   assign w_rd_idx    = IdxW'(word_index(w_addr_next));
   assign w_addr_adv  = (r_burst == BurstFixed) ? r_addr : r_addr + AxiAddrWidth'(8);

   always_comb begin
      w_state_next = r_state;
      w_addr_next  = r_addr;
      w_resp       = '0;
      case (r_state)
         IDLE: begin
            w_resp.aw_ready = 1'b1;
            w_resp.ar_ready = !axi_req_i.aw_valid;
            if (axi_req_i.aw_valid) begin
               w_state_next = WRITE;
               w_addr_next  = AxiAddrWidth'(axi_req_i.aw_addr);
            end else if (axi_req_i.ar_valid) begin
               w_state_next = READ;
               w_addr_next  = AxiAddrWidth'(axi_req_i.ar_addr);
            end
         end
         WRITE: begin
            w_resp.w_ready = 1'b1;
            if (axi_req_i.w_valid) begin
               // Either end marker closes the burst; a disagreement is flagged in r_slverr.
               if (axi_req_i.w_last || w_last_beat) begin
                  w_state_next = WRESP;
               end else begin
                  w_addr_next = w_addr_adv;
               end
            end
         end
         WRESP: begin
            w_resp.b_valid = 1'b1;
            w_resp.b_id    = IdW'(r_id);
            w_resp.b_resp  = r_slverr ? RespSlvErr : (r_decerr ? RespDecErr : RespOkay);
            if (axi_req_i.b_ready) begin
               w_state_next = IDLE;
            end
         end
         READ: begin
            w_resp.r_valid = 1'b1;
            w_resp.r_id    = IdW'(r_id);
            w_resp.r_data  = (r_rd_in_range && !r_slverr) ? DataW'(r_rdata) : '0;
            w_resp.r_resp  = r_slverr ? RespSlvErr : (r_rd_in_range ? RespOkay : RespDecErr);
            w_resp.r_last  = w_last_beat;
            if (axi_req_i.r_ready) begin
               if (w_last_beat) begin
                  w_state_next = IDLE;
               end else begin
                  w_addr_next = w_addr_adv;
               end
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   assign axi_resp_o = w_resp;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state       <= IDLE;
         r_id          <= '0;
         r_addr        <= '0;
         r_len         <= '0;
         r_cnt         <= '0;
         r_burst       <= '0;
         r_slverr      <= 1'b0;
         r_decerr      <= 1'b0;
         r_rd_in_range <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_addr        <= w_addr_next;
         r_rd_in_range <= in_range(w_addr_next);
         if (w_aw_hs) begin
            r_id     <= AxiIdWidth'(axi_req_i.aw_id);
            r_len    <= axi_req_i.aw_len;
            r_burst  <= axi_req_i.aw_burst;
            r_cnt    <= '0;
            r_decerr <= 1'b0;
            r_slverr <= (axi_req_i.aw_burst == BurstWrap) || (axi_req_i.aw_size != 3'd3) ||
                        (axi_req_i.aw_atop != 6'd0);
         end else if (w_ar_hs) begin
            r_id     <= AxiIdWidth'(axi_req_i.ar_id);
            r_len    <= axi_req_i.ar_len;
            r_burst  <= axi_req_i.ar_burst;
            r_cnt    <= '0;
            r_decerr <= 1'b0;
            r_slverr <= (axi_req_i.ar_burst == BurstWrap) || (axi_req_i.ar_size != 3'd3);
         end
         if (w_w_hs) begin
            if (!w_cur_ok) begin
               r_decerr <= 1'b1;
            end
            if (axi_req_i.w_last != w_last_beat) begin
               r_slverr <= 1'b1;
            end
            if (!w_last_beat) begin
               r_cnt <= r_cnt + 8'd1;
            end
         end
         if (w_r_hs && !w_last_beat) begin
            r_cnt <= r_cnt + 8'd1;
         end
      end
   end

   // Memory has no reset so contents survive rst_i; the read port prefetches the next beat.
   always_ff @(posedge clk_i) begin
      if (w_mem_we) begin
         for (int b = 0; b < StrbWidth; b++) begin
            if (axi_req_i.w_strb[b]) begin
               r_mem[w_wr_idx][b*8 +: 8] <= axi_req_i.w_data[b*8 +: 8];
            end
         end
      end
      r_rdata <= r_mem[w_rd_idx];
   end
endmodule

// File: doc/axi_wb_mem_responder.md
AXI_WB_MEM_RESPONDER -- requirements
Module: axi_wb_mem_responder

Interface
REQ-001 SHALL have parameter AxiAddrWidth, default 64, AXI address width in bits.
REQ-002 SHALL have parameter AxiDataWidth, default 64, AXI data width; only 64 is supported.
REQ-003 SHALL have parameter AxiIdWidth, default 4, AXI ID width.
REQ-004 SHALL have parameter MemBase, default 64'h8000_0000, byte address of memory word 0.
REQ-005 SHALL have parameter MemWords, default 1024, number of 64-bit words held.
REQ-006 SHALL have port clk_i, input, 1 bit, the single clock; all logic is rising-edge.
REQ-007 SHALL have port rst_i, input, 1 bit; reset is synchronous and active-high.
REQ-008 SHALL have port axi_req_i, input, AXI4+ATOP request struct, carrying the AW, W, AR channels plus b_ready and r_ready.
REQ-009 SHALL have port axi_resp_o, output, AXI4 response struct, carrying aw_ready, w_ready, ar_ready and the B and R channels.

Function
REQ-010 SHALL act as an AXI4 subordinate serving a write-back dcache manager; one transaction in flight at a time.
REQ-011 SHALL use FSM states IDLE, WRITE, WRESP, READ.
REQ-012 IDLE: aw_ready=1; ar_ready=1 only when aw_valid=0; when aw_valid and ar_valid are both high, the write is accepted first and the read waits.
REQ-013 On AW handshake: latch id, addr, len, burst, size, atop; go to WRITE.
REQ-014 WRITE: w_ready=1; each W handshake writes the bytes enabled by w_strb to the current word; last beat (w_last, or beat count = len) goes to WRESP.
REQ-015 WRESP: b_valid=1 with the latched id; hold b_valid and b_id/b_resp stable until b_ready; on handshake go to IDLE.
REQ-016 On AR handshake: latch id, addr, len, burst, size; go to READ; first r_valid is asserted the cycle after the AR handshake.
REQ-017 READ: r_valid=1 with the word at the current address, r_id = latched id, r_last=1 on beat len; hold all R fields stable while r_ready=0; after the last handshake go to IDLE.
REQ-018 Word index = (addr - MemBase) >> 3. INCR increments it by 1 per beat; FIXED keeps it constant.
REQ-019 Beat is in range when addr >= MemBase and index < MemWords; index is recomputed per beat.
REQ-020 An out-of-range write beat is dropped and sets the sticky error; an out-of-range read beat returns data 0 and r_resp=DECERR.
REQ-021 WRAP burst, size != 3, or nonzero atop: the whole transaction gets SLVERR; all W beats are accepted but none is written; each read beat returns 0.
REQ-022 b_resp SHALL be OKAY unless any beat erred: DECERR takes precedence over OKAY, and SLVERR takes precedence over DECERR.
REQ-023 W beats arriving before AW SHALL NOT be accepted: w_ready=0 outside WRITE.
REQ-024 Early w_last (before beat len): go to WRESP with SLVERR.
REQ-025 Missing w_last on beat len: go to WRESP with SLVERR; the extra beat is not accepted.
REQ-026 len up to 255 is supported; the beat counter is 8 bits and never wraps within a transaction.

Reset
REQ-027 While rst_i=1 at a clock edge: FSM returns to IDLE; outputs from the next cycle are aw_ready=1, ar_ready=1, w_ready=0, b_valid=0, r_valid=0, r_last=0, all ID/data/resp fields 0.
REQ-028 Reset mid-burst SHALL abandon the transaction with no further B or R beat.
REQ-029 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-030 Cache-line write then read: AW addr=0x8000_0010, len=1, INCR, size=3, id=5; W beats 0x11..11 then 0x22..22 with strb=0xFF -> B id=5 OKAY. AR same addr/id -> R beats in that order, r_last on beat 2, OKAY.
REQ-031 Partial strobe: word at 0x8000_0000 holds 0xFFFF..FF; write 0 with strb=0x0F -> read returns 0xFFFF_FFFF_0000_0000.
REQ-032 Simultaneous AW and AR at cycle 0 -> AW handshake in cycle 0; AR handshake only after the B handshake; read returns the newly written data.
REQ-033 Boundary: INCR len=1 starting at the last word (index 1023) -> beat 1 written, beat 2 dropped, b_resp=DECERR. Read of the same range -> data then 0, r_resp OKAY then DECERR.
REQ-034 atop=6'h20 write -> all W beats accepted, memory unchanged, b_resp=SLVERR.
REQ-035 Backpressure: r_ready=0 for 3 cycles mid-burst -> r_data and r_last stable throughout. Assert rst_i during READ -> r_valid=0 the next cycle, FSM in IDLE, memory preserved.
